// File: rtl/disp_write_arbiter.sv
// Two-requester, message-locked arbiter for a character display write bus.
// Each accepted byte is shown on lcd_data and strobed with a timed lcd_e pulse.
module disp_write_arbiter #(
    parameter int unsigned E_HIGH = 4,
    parameter int unsigned E_GAP  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    input  logic       req0_last,
    input  logic       req1_last,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [1:0] gnt,
    output logic [7:0] lcd_data,
    output logic       lcd_e,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_e;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [7:0] HIGH_LOAD = 8'(E_HIGH - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(E_GAP - 1);

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       e_q, e_d;
    logic       ptr_q, ptr_d;   // 1 = req1 owned the most recently finished message
    logic       handshake;

    assign req0_ready = (state_q == ST_WAIT) && gnt_q[0];
    assign req1_ready = (state_q == ST_WAIT) && gnt_q[1];
    assign handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign gnt      = gnt_q;
    assign lcd_data = data_q;
    assign lcd_e    = e_q;
    assign busy     = (state_q != ST_IDLE);

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = ST_WAIT;
                    if (req0_valid && req1_valid) gnt_d = ptr_q ? 2'b01 : 2'b10;
                    else                          gnt_d = req0_valid ? 2'b01 : 2'b10;
                end
            end
            ST_WAIT: begin
                // Grant is held even with valid low so a message is never split.
                if (handshake) begin
                    data_d  = gnt_q[0] ? req0_data : req1_data;
                    last_d  = gnt_q[0] ? req0_last : req1_last;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = HIGH_LOAD;
            end
            ST_PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        gnt_d   = 2'b00;
                        ptr_d   = gnt_q[1];
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Registering the strobe from the next state keeps lcd_e glitch-free and aligned with PULSE.
    assign e_d = (state_d == ST_PULSE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            cnt_q   <= 8'h00;
            e_q     <= 1'b0;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_disp_write_arbiter.sv
// Directed bench for disp_write_arbiter: timing of each write, arbitration order,
// message locking, hold-off of late requests and asynchronous reset mid-pulse.
module tb_disp_write_arbiter;

    localparam int unsigned E_HIGH = 4;
    localparam int unsigned E_GAP  = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic [1:0] gnt;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    disp_write_arbiter #(.E_HIGH(E_HIGH), .E_GAP(E_GAP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .req0_last  (req0_last),
        .req1_last  (req1_last),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .gnt        (gnt),
        .lcd_data   (lcd_data),
        .lcd_e      (lcd_e),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_lcd_e", 32'(lcd_e), 32'd0);
        check("rst_data",  32'(lcd_data), 32'd0);
        check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        reset_n = 1'b1;
        tick();
    endtask

    // Sends one byte from src and checks the full strobe timeline through t+14.
    // Optionally raises the other requester during the second PULSE cycle.
    task automatic xfer(input string tag, input int src, input logic [7:0] d, input logic l,
                        input bit raise_other, input logic [7:0] od, input logic ol);
        logic [1:0] exp_gnt;
        logic       own_ready;
        int         hi_cnt;
        int         first_hi;
        bit         data_ok;
        bit         ready_ok;
        int         n;
        exp_gnt = (src == 0) ? 2'b01 : 2'b10;
        set_req(src, 1'b1, d, l);
        n = 0;
        while (gnt == 2'b00 && n < 300) begin
            tick();
            n++;
        end
        if (gnt == 2'b00) begin
            check({tag, "_grant_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        own_ready = (src == 0) ? req0_ready : req1_ready;
        check({tag, "_ready"}, 32'(own_ready), 32'd1);
        if (!own_ready) return;
        tick();
        // Inputs scrambled right after the handshake must not disturb the latched byte.
        set_req(src, 1'b0, 8'hFF, 1'b0);
        check({tag, "_setup_data"}, 32'(lcd_data), 32'(d));
        check({tag, "_setup_e"},    32'(lcd_e), 32'd0);
        hi_cnt = 0; first_hi = -1; data_ok = 1'b1; ready_ok = 1'b1;
        for (int i = 2; i <= 13; i++) begin
            tick();
            if (lcd_e) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (lcd_data !== d) data_ok = 1'b0;
            if (req0_ready || req1_ready || !busy) ready_ok = 1'b0;
            if (raise_other && i == 3) set_req(1 - src, 1'b1, od, ol);
        end
        check({tag, "_e_high_cycles"}, 32'(hi_cnt), 32'(E_HIGH));
        check({tag, "_e_first_cycle"}, 32'(first_hi), 32'd2);
        check({tag, "_data_stable"},   32'(data_ok), 32'd1);
        check({tag, "_held_off"},      32'(ready_ok), 32'd1);
        tick();
        check({tag, "_end_e"},    32'(lcd_e), 32'd0);
        check({tag, "_end_data"}, 32'(lcd_data), 32'(d));
        if (l) begin
            check({tag, "_end_busy"}, 32'(busy), 32'd0);
            check({tag, "_end_gnt"},  32'(gnt), 32'd0);
        end else begin
            check({tag, "_end_gnt"},   32'(gnt), 32'(exp_gnt));
            check({tag, "_end_ready"}, 32'((src == 0) ? req0_ready : req1_ready), 32'd1);
        end
    endtask

    initial begin
        bit lock_ok;

        // Two-byte message from req0.
        apply_reset();
        xfer("m31_b0", 0, 8'd90, 1'b0, 1'b0, 8'h00, 1'b0);
        xfer("m31_b1", 0, 8'd65, 1'b1, 1'b0, 8'h00, 1'b0);

        // Tie on the first cycle after reset: req0 first, then req1.
        apply_reset();
        set_req(1, 1'b1, 8'd83, 1'b1);
        xfer("tie_r0", 0, 8'd32, 1'b1, 1'b0, 8'h00, 1'b0);
        xfer("tie_r1", 1, 8'd83, 1'b1, 1'b0, 8'h00, 1'b0);

        // Both continuously requesting single-byte messages: grant alternates.
        apply_reset();
        set_req(1, 1'b1, 8'h41, 1'b1);
        xfer("rr_0", 0, 8'h30, 1'b1, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h31, 1'b1);
        xfer("rr_1", 1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b1, 8'h42, 1'b1);
        xfer("rr_2", 0, 8'h31, 1'b1, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h32, 1'b1);
        xfer("rr_3", 1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b0, 8'h00, 1'b0);

        // Message lock: req0 pauses mid-message while req1 waits.
        apply_reset();
        set_req(1, 1'b1, 8'd83, 1'b1);
        xfer("lock_b0", 0, 8'd71, 1'b0, 1'b0, 8'h00, 1'b0);
        lock_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (gnt != 2'b01 || req1_ready || lcd_e) lock_ok = 1'b0;
            tick();
        end
        check("lock_pause", 32'(lock_ok), 32'd1);
        xfer("lock_b1", 0, 8'd32, 1'b1, 1'b0, 8'h00, 1'b0);
        xfer("lock_r1", 1, 8'd83, 1'b1, 1'b0, 8'h00, 1'b0);

        // req1 raised during req0's PULSE is held off and then served.
        apply_reset();
        xfer("late_r0", 0, 8'h55, 1'b1, 1'b1, 8'hA7, 1'b1);
        xfer("late_r1", 1, 8'hA7, 1'b1, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the second PULSE cycle.
        apply_reset();
        set_req(0, 1'b1, 8'd90, 1'b1);
        tick();
        check("arst_gnt", 32'(gnt), 32'd1);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("arst_pulse_e", 32'(lcd_e), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_e",     32'(lcd_e), 32'd0);
        check("arst_data",  32'(lcd_data), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_gnt0",  32'(gnt), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("arst_after_gnt",  32'(gnt), 32'd0);
        check("arst_after_busy", 32'(busy), 32'd0);
        check("arst_after_e",    32'(lcd_e), 32'd0);
        xfer("arst_fresh", 0, 8'd65, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
